// File: rtl/queue_occupancy_counter.sv
// ---------------------------------------------------------------------------
// queue_occupancy_counter
//
// Turns raw, asynchronous, active-low arrival/departure sensor pulses into a
// saturating occupancy count. Each sensor goes through a reset-to-1
// synchroniser, then a stable-level debounce filter, then falling-edge
// detection. The resulting events drive a counter clamped to
// [0, CAPACITY], with peak tracking and sticky overflow/underflow flags.
//
// Parameters
//   WIDTH            width of stateOutput / peakCount
//   CAPACITY         maximum occupancy (1 .. 2^WIDTH-1)
//   SYNC_STAGES      synchroniser flops per sensor (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing clocks before the filtered level
//                    follows the synchronised level (>= 1)
//
// Ports
//   clk           rising-edge system clock
//   reset         asynchronous active-low reset
//   upSignal      arrival sensor, idle high, low pulse = one arrival
//   downSignal    departure sensor, idle high, low pulse = one departure
//   errClear      synchronous clear of both sticky error flags
//   stateOutput   current occupancy (registered)
//   peakCount     highest occupancy since reset (registered)
//   full          stateOutput == CAPACITY
//   empty         stateOutput == 0
//   arriveStrobe  one-cycle pulse on the edge an arrival changes the count
//   departStrobe  one-cycle pulse on the edge a departure changes the count
//   overflowErr   sticky: an arrival was rejected at CAPACITY
//   underflowErr  sticky: a departure was rejected at 0
//
// There is no valid/ready handshake: events are single-cycle pulses that are
// always consumed on the edge after the filtered level falls.
// ---------------------------------------------------------------------------
module queue_occupancy_counter #(
  parameter int WIDTH           = 3,
  parameter int CAPACITY        = 7,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upSignal,
  input  logic             downSignal,
  input  logic             errClear,
  output logic [WIDTH-1:0] stateOutput,
  output logic [WIDTH-1:0] peakCount,
  output logic             full,
  output logic             empty,
  output logic             arriveStrobe,
  output logic             departStrobe,
  output logic             overflowErr,
  output logic             underflowErr
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CAP_W    = WIDTH'(CAPACITY);

  // Index 0 = arrival sensor, index 1 = departure sensor.
  logic [1:0] pad;
  logic [1:0] fall;

  assign pad = {downSignal, upSignal};

  for (genvar s = 0; s < 2; s++) begin : g_sensor
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q;
    logic                   filt_d_q;
    logic [CW-1:0]          cnt_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q   <= '1;
        filt_q   <= 1'b1;
        filt_d_q <= 1'b1;
        cnt_q    <= '0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], pad[s]};
        filt_d_q <= filt_q;
        if (sync_lvl != filt_q) begin
          // The DEBOUNCE_CYCLES-th consecutive differing clock commits the
          // new level; any agreeing clock in between restarts the run.
          if (cnt_q == CNT_LAST) begin
            filt_q <= sync_lvl;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    // Registered previous level keeps the event one edge behind the filter,
    // which gives the SYNC + DEBOUNCE + 1 pad-to-count latency.
    assign fall[s] = filt_d_q & ~filt_q;
  end

  logic             arrive;
  logic             depart;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] peak_next;
  logic             arrive_next;
  logic             depart_next;
  logic             ovf_set;
  logic             udf_set;

  assign arrive = fall[0];
  assign depart = fall[1];

  always_comb begin
    state_next  = stateOutput;
    arrive_next = 1'b0;
    depart_next = 1'b0;
    ovf_set     = 1'b0;
    udf_set     = 1'b0;
    // Simultaneous arrival and departure cancel: no change, no error.
    if (arrive && !depart) begin
      if (stateOutput < CAP_W) begin
        state_next  = stateOutput + 1'b1;
        arrive_next = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (depart && !arrive) begin
      if (stateOutput != '0) begin
        state_next  = stateOutput - 1'b1;
        depart_next = 1'b1;
      end else begin
        udf_set = 1'b1;
      end
    end
    peak_next = (state_next > peakCount) ? state_next : peakCount;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateOutput  <= '0;
      peakCount    <= '0;
      arriveStrobe <= 1'b0;
      departStrobe <= 1'b0;
      overflowErr  <= 1'b0;
      underflowErr <= 1'b0;
    end else begin
      stateOutput  <= state_next;
      peakCount    <= peak_next;
      arriveStrobe <= arrive_next;
      departStrobe <= depart_next;
      // Setting takes priority over a clear in the same cycle.
      if (ovf_set)       overflowErr <= 1'b1;
      else if (errClear) overflowErr <= 1'b0;
      if (udf_set)       underflowErr <= 1'b1;
      else if (errClear) underflowErr <= 1'b0;
    end
  end

  assign full  = (stateOutput == CAP_W);
  assign empty = (stateOutput == '0);

endmodule

// File: tb/tb_queue_occupancy_counter.sv
// ---------------------------------------------------------------------------
// tb_queue_occupancy_counter
//
// Directed bench for queue_occupancy_counter at default parameters. A
// behavioural model (pad-sample history, saturating integer count) predicts
// every output on every clock; directed sequences add hand-computed literal
// expectations at key points.
// ---------------------------------------------------------------------------
module tb_queue_occupancy_counter;

  localparam int W   = 3;
  localparam int CAP = 7;
  localparam int SS  = 2;
  localparam int DB  = 4;

  // ---------------- clock / reset ----------------
  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic up        = 1'b1;
  logic down      = 1'b1;
  logic err_clear = 1'b0;

  logic [W-1:0] state_output;
  logic [W-1:0] peak_count;
  logic         full;
  logic         empty;
  logic         arrive_strobe;
  logic         depart_strobe;
  logic         overflow_err;
  logic         underflow_err;

  always #5 clk = ~clk;

  queue_occupancy_counter #(
    .WIDTH(W), .CAPACITY(CAP), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .upSignal(up),
    .downSignal(down),
    .errClear(err_clear),
    .stateOutput(state_output),
    .peakCount(peak_count),
    .full(full),
    .empty(empty),
    .arriveStrobe(arrive_strobe),
    .departStrobe(depart_strobe),
    .overflowErr(overflow_err),
    .underflowErr(underflow_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each sensor keeps its sampled pad levels, newest first. The filtered
  // level flips once the synchronised samples (delayed by SS edges) have
  // shown the opposite level for DB edges in a row; a 1->0 flip becomes an
  // event that is applied to the count on the following edge.
  bit hist_up[$];
  bit hist_dn[$];
  bit filt_up, filt_dn;
  bit pend_up, pend_dn;
  int m_cnt, m_peak;
  bit m_as, m_ds, m_ovf, m_udf;

  function automatic bit run_flip(input bit h[$], input bit f);
    for (int i = SS; i < SS + DB; i++)
      if (h[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist_up.delete();
    hist_dn.delete();
    for (int i = 0; i < SS + DB; i++) begin
      hist_up.push_back(1'b1);
      hist_dn.push_back(1'b1);
    end
    filt_up = 1'b1; filt_dn = 1'b1;
    pend_up = 1'b0; pend_dn = 1'b0;
    m_cnt = 0; m_peak = 0;
    m_as = 1'b0; m_ds = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model_step(input bit u, input bit d, input bit clr);
    bit ovf_set, udf_set;
    ovf_set = 1'b0; udf_set = 1'b0;
    m_as = 1'b0; m_ds = 1'b0;
    if (pend_up && !pend_dn) begin
      if (m_cnt < CAP) begin m_cnt++; m_as = 1'b1; end
      else ovf_set = 1'b1;
    end else if (pend_dn && !pend_up) begin
      if (m_cnt > 0) begin m_cnt--; m_ds = 1'b1; end
      else udf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (udf_set) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    if (m_cnt > m_peak) m_peak = m_cnt;

    hist_up.push_front(u); void'(hist_up.pop_back());
    hist_dn.push_front(d); void'(hist_dn.pop_back());

    pend_up = 1'b0;
    if (run_flip(hist_up, filt_up)) begin
      pend_up = filt_up;
      filt_up = ~filt_up;
    end
    pend_dn = 1'b0;
    if (run_flip(hist_dn, filt_dn)) begin
      pend_dn = filt_dn;
      filt_dn = ~filt_dn;
    end
  endtask

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) model_reset();
      else model_step(up, down, err_clear);
      #1;
      chk("state",         state_output,  m_cnt);
      chk("peak",          peak_count,    m_peak);
      chk("full",          full,          (m_cnt == CAP) ? 1 : 0);
      chk("empty",         empty,         (m_cnt == 0) ? 1 : 0);
      chk("arrive_strobe", arrive_strobe, m_as);
      chk("depart_strobe", depart_strobe, m_ds);
      chk("overflow",      overflow_err,  m_ovf);
      chk("underflow",     underflow_err, m_udf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input bit do_up, input bit do_dn, input int lo, input int hi);
    @(negedge clk);
    if (do_up) up = 1'b0;
    if (do_dn) down = 1'b0;
    repeat (lo) @(negedge clk);
    up = 1'b1;
    down = 1'b1;
    repeat (hi - 1) @(negedge clk);
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_state", state_output, 0);
    chk("rst_peak",  peak_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_ovf",   overflow_err, 0);
    chk("rst_udf",   underflow_err, 0);

    // First arrival: measure pad-to-strobe latency.
    @(negedge clk);
    up = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (arrive_strobe) begin lat = i; break; end
    end
    chk("arrive_latency", lat, 7);
    if (lat < 10) repeat (10 - lat) @(posedge clk);
    @(negedge clk);
    up = 1'b1;
    repeat (9) @(negedge clk);
    chk("arrive_1", state_output, 1);

    // Arrivals 2..9: count saturates at 7.
    for (int k = 2; k <= 9; k++) begin
      pulse(1'b1, 1'b0, 10, 10);
      chk("arrive_step", state_output, (k < CAP) ? k : CAP);
    end
    chk("sat_full", full, 1);
    chk("sat_ovf",  overflow_err, 1);
    chk("sat_peak", peak_count, 7);
    chk("sat_udf",  underflow_err, 0);

    // Departures 1..9: count reaches 0, underflow on the 8th.
    for (int k = 1; k <= 9; k++) begin
      pulse(1'b0, 1'b1, 10, 10);
      chk("depart_step", state_output, (7 - k > 0) ? 7 - k : 0);
      if (k == 7) chk("udf_before_8th", underflow_err, 0);
      if (k == 8) chk("udf_on_8th", underflow_err, 1);
    end
    chk("dep_empty", empty, 1);
    chk("dep_peak",  peak_count, 7);
    clear_errors();
    chk("clr_ovf", overflow_err, 0);
    chk("clr_udf", underflow_err, 0);

    // Glitch filter.
    pulse(1'b1, 1'b0, 3, 10);
    chk("glitch_3", state_output, 0);
    pulse(1'b1, 1'b0, 5, 10);
    chk("pulse_5", state_output, 1);

    // Simultaneous events at 3, 0 and 7.
    pulse(1'b1, 1'b0, 10, 10);
    pulse(1'b1, 1'b0, 10, 10);
    chk("reach_3", state_output, 3);
    pulse(1'b1, 1'b1, 10, 10);
    chk("simul_3", state_output, 3);
    repeat (3) pulse(1'b0, 1'b1, 10, 10);
    pulse(1'b1, 1'b1, 10, 10);
    chk("simul_0", state_output, 0);
    chk("simul_0_udf", underflow_err, 0);
    repeat (7) pulse(1'b1, 1'b0, 10, 10);
    pulse(1'b1, 1'b1, 10, 10);
    chk("simul_7", state_output, 7);
    chk("simul_7_ovf", overflow_err, 0);

    // errClear on the same edge as an overflow: the set wins.
    @(negedge clk);
    up = 1'b0;
    repeat (6) @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("set_wins_ovf", overflow_err, 1);
    repeat (3) @(negedge clk);
    up = 1'b1;
    repeat (10) @(negedge clk);
    chk("set_wins_hold", overflow_err, 1);
    clear_errors();

    // Held-low sensor counts once.
    pulse(1'b0, 1'b1, 10, 10);
    chk("held_pre", state_output, 6);
    pulse(1'b1, 1'b0, 100, 10);
    chk("held_once", state_output, 7);
    chk("held_ovf", overflow_err, 0);

    // Reset during a held-low arrival: counting restarts from 0.
    @(negedge clk);
    up = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("reset_mid_state", state_output, 1);
    chk("reset_mid_peak",  peak_count, 1);
    up = 1'b1;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run is bounded even if the stimulus stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
